// File: rtl/lab2_proc_pkg.sv
// Shared definitions for the lab2 processor multiplier-sharing blocks.
package lab2_proc_pkg;
    localparam int REQ_MSG_W  = 64;
    localparam int RESP_MSG_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/lab2_proc_rr_arb2.sv
// Two-way round-robin arbiter; the priority register names the favoured requester.
module lab2_proc_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] reqs,
    input  logic       en,
    output logic [1:0] grants
);
    logic prio;

    always_comb begin
        grants = reqs;
        if (reqs == 2'b11) grants = prio ? 2'b10 : 2'b01;
    end

    // After a grant, the requester that did not win becomes favoured.
    always_ff @(posedge clk) begin
        if (reset) prio <= 1'b0;
        else if (en && (grants != 2'b00)) prio <= grants[0];
    end
endmodule

// File: rtl/lab2_proc_imul_share_arb.sv
// Shares one iterative multiplier between two requesters, one transaction at a time.
//   state | meaning
//   IDLE  | nothing outstanding; grant passes straight through to the multiplier
//   BUSY  | one transaction outstanding; response routed back to the owner
module lab2_proc_imul_share_arb
    import lab2_proc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_val,
    output logic                  req0_rdy,
    input  logic [REQ_MSG_W-1:0]  req0_msg,
    input  logic                  req1_val,
    output logic                  req1_rdy,
    input  logic [REQ_MSG_W-1:0]  req1_msg,
    output logic                  resp0_val,
    input  logic                  resp0_rdy,
    output logic [RESP_MSG_W-1:0] resp0_msg,
    output logic                  resp1_val,
    input  logic                  resp1_rdy,
    output logic [RESP_MSG_W-1:0] resp1_msg,
    output logic                  imul_req_val,
    input  logic                  imul_req_rdy,
    output logic [REQ_MSG_W-1:0]  imul_req_msg,
    input  logic                  imul_resp_val,
    output logic                  imul_resp_rdy,
    input  logic [RESP_MSG_W-1:0] imul_resp_msg,
    output logic [31:0]           done_count0,
    output logic [31:0]           done_count1
);
    state_t     state, state_next;
    logic       owner;
    logic [1:0] reqs, grants;
    logic       req_go, resp_go;

    assign reqs    = (state == IDLE && !reset) ? {req1_val, req0_val} : 2'b00;
    assign req_go  = imul_req_val && imul_req_rdy;
    assign resp_go = imul_resp_val && imul_resp_rdy;

    lab2_proc_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .reqs   (reqs),
        .en     (req_go),
        .grants (grants)
    );

    always_comb begin
        state_next    = state;
        imul_req_val  = 1'b0;
        imul_req_msg  = '0;
        req0_rdy      = 1'b0;
        req1_rdy      = 1'b0;
        resp0_val     = 1'b0;
        resp0_msg     = '0;
        resp1_val     = 1'b0;
        resp1_msg     = '0;
        imul_resp_rdy = 1'b0;
        if (state == IDLE) begin
            imul_req_val = |grants;
            if (grants[1])      imul_req_msg = req1_msg;
            else if (grants[0]) imul_req_msg = req0_msg;
            req0_rdy = grants[0] && imul_req_rdy;
            req1_rdy = grants[1] && imul_req_rdy;
            if (imul_req_val && imul_req_rdy) state_next = BUSY;
        end else if (!reset) begin
            if (owner) begin
                resp1_val     = imul_resp_val;
                resp1_msg     = imul_resp_msg;
                imul_resp_rdy = resp1_rdy;
            end else begin
                resp0_val     = imul_resp_val;
                resp0_msg     = imul_resp_msg;
                imul_resp_rdy = resp0_rdy;
            end
            // Returning to IDLE leaves a one-cycle bubble before the next grant.
            if (imul_resp_val && imul_resp_rdy) state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            done_count0 <= 32'd0;
            done_count1 <= 32'd0;
        end else begin
            state <= state_next;
            if (req_go) owner <= grants[1];
            if (resp_go && !owner) done_count0 <= done_count0 + 32'd1;
            if (resp_go && owner)  done_count1 <= done_count1 + 32'd1;
        end
    end
endmodule

// File: tb/tb_lab2_proc_imul_share_arb.sv
// Directed scoreboard bench for the shared-multiplier arbiter with a 4-cycle multiplier model.
module tb_lab2_proc_imul_share_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [63:0] req0_msg, req1_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [31:0] resp0_msg, resp1_msg;
    logic        imul_req_val, imul_req_rdy, imul_resp_val, imul_resp_rdy;
    logic [63:0] imul_req_msg;
    logic [31:0] imul_resp_msg;
    logic [31:0] done_count0, done_count1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] src0[$], src1[$];
    logic [31:0] exp0[$], exp1[$];
    int          exp_grant[$], gcyc[$], rcyc[$];
    logic        agent_en, spur, mstall, cur_owner;

    logic        m_busy;
    logic [2:0]  m_cnt;
    logic [31:0] m_prod;

    always #5 clk = ~clk;

    lab2_proc_imul_share_arb dut (
        .clk           (clk),
        .reset         (reset),
        .req0_val      (req0_val),
        .req0_rdy      (req0_rdy),
        .req0_msg      (req0_msg),
        .req1_val      (req1_val),
        .req1_rdy      (req1_rdy),
        .req1_msg      (req1_msg),
        .resp0_val     (resp0_val),
        .resp0_rdy     (resp0_rdy),
        .resp0_msg     (resp0_msg),
        .resp1_val     (resp1_val),
        .resp1_rdy     (resp1_rdy),
        .resp1_msg     (resp1_msg),
        .imul_req_val  (imul_req_val),
        .imul_req_rdy  (imul_req_rdy),
        .imul_req_msg  (imul_req_msg),
        .imul_resp_val (imul_resp_val),
        .imul_resp_rdy (imul_resp_rdy),
        .imul_resp_msg (imul_resp_msg),
        .done_count0   (done_count0),
        .done_count1   (done_count1)
    );

    // Multiplier model: answers 4 cycles after acceptance and holds until taken.
    assign imul_req_rdy  = !m_busy && !mstall;
    assign imul_resp_val = (m_busy && m_cnt == 3'd0) || spur;
    assign imul_resp_msg = m_prod;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 3'd0;
            m_prod <= 32'd0;
        end else if (!m_busy) begin
            if (imul_req_val && imul_req_rdy) begin
                m_busy <= 1'b1;
                m_cnt  <= 3'd3;
                m_prod <= imul_req_msg[63:32] * imul_req_msg[31:0];
            end
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
        end else if (imul_resp_rdy) begin
            m_busy <= 1'b0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push0(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        src0.push_back({a, b});
        exp0.push_back(e);
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        src1.push_back({a, b});
        exp1.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
        exp_grant.delete(); gcyc.delete(); rcyc.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, (n < budget) ? 64'd1 : 64'd0, 64'd1);
        @(negedge clk);
    endtask

    // Requester agents: present queued messages, advance on handshake.
    initial begin
        logic f0, f1;
        forever begin
            @(negedge clk);
            f0 = req0_val && req0_rdy;
            f1 = req1_val && req1_rdy;
            @(posedge clk); #1;
            if (agent_en) begin
                if (f0 && src0.size() > 0) void'(src0.pop_front());
                if (f1 && src1.size() > 0) void'(src1.pop_front());
                if (src0.size() > 0) begin req0_val = 1'b1; req0_msg = src0[0]; end
                else begin req0_val = 1'b0; req0_msg = 64'd0; end
                if (src1.size() > 0) begin req1_val = 1'b1; req1_msg = src1[0]; end
                else begin req1_val = 1'b0; req1_msg = 64'd0; end
            end
        end
    end

    // Monitor: scoreboard pops plus per-cycle protocol checks.
    initial begin
        forever begin
            @(negedge clk);
            if (reset)
                chk("reset_valrdy", {req0_rdy, req1_rdy, resp0_val, resp1_val, imul_req_val, imul_resp_rdy}, 64'd0);
            if (imul_req_val && imul_req_rdy) begin
                if (exp_grant.size() > 0) chk("grant_id", {63'd0, req1_rdy}, exp_grant.pop_front());
                else chk("grant_unexp", {63'd0, imul_req_val}, 64'd0);
                chk("grant_msg", imul_req_msg, req1_rdy ? req1_msg : req0_msg);
                chk("grant_one_rdy", {62'd0, req1_rdy, req0_rdy} , req1_rdy ? 64'd2 : 64'd1);
                cur_owner = req1_rdy;
                gcyc.push_back(cyc);
            end
            if (resp0_val && resp0_rdy) begin
                if (exp0.size() > 0) chk("resp0_msg", resp0_msg, exp0.pop_front());
                else chk("resp0_unexp", {63'd0, resp0_val}, 64'd0);
            end
            if (resp1_val && resp1_rdy) begin
                if (exp1.size() > 0) chk("resp1_msg", resp1_msg, exp1.pop_front());
                else chk("resp1_unexp", {63'd0, resp1_val}, 64'd0);
            end
            if (imul_resp_val && imul_resp_rdy) rcyc.push_back(cyc);
            if (m_busy && !reset) begin
                chk("busy_holdoff", {imul_req_val, req0_rdy, req1_rdy}, 64'd0);
                if (cur_owner) chk("busy_nonowner0", {resp0_val, resp0_msg}, 64'd0);
                else           chk("busy_nonowner1", {resp1_val, resp1_msg}, 64'd0);
            end
            if (!m_busy) chk("idle_no_resp", {resp0_val, resp1_val, imul_resp_rdy}, 64'd0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; agent_en = 1'b0; spur = 1'b0; mstall = 1'b0; cur_owner = 1'b0;
        req0_val = 1'b1; req0_msg = {32'd1, 32'd1};
        req1_val = 1'b1; req1_msg = {32'd2, 32'd2};
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;

        // Reset held with requests pending: everything quiet.
        repeat (3) @(negedge clk);
        chk("rst_req0_rdy", {63'd0, req0_rdy}, 64'd0);
        chk("rst_imul_req_val", {63'd0, imul_req_val}, 64'd0);
        @(posedge clk); #1;
        req0_val = 1'b0; req1_val = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rst_done0", done_count0, 64'd0);
        chk("rst_done1", done_count1, 64'd0);
        chk("idle_req_val", {63'd0, imul_req_val}, 64'd0);
        chk("idle_req_msg", imul_req_msg, 64'd0);
        agent_en = 1'b1;

        // Single requester.
        push0(32'd3, 32'd5, 32'd15); exp_grant.push_back(0);
        wait_drain("single_drain", 100);
        chk("single_done0", done_count0, 64'd1);
        chk("single_done1", done_count1, 64'd0);

        // Simultaneous after reset: req0 first, bubble before req1.
        do_reset();
        push0(32'd2, 32'd7, 32'd14); push1(32'd4, 32'd4, 32'd16);
        exp_grant.push_back(0); exp_grant.push_back(1);
        wait_drain("simul_drain", 100);
        chk("simul_ngrant", gcyc.size(), 64'd2);
        if (gcyc.size() == 2 && rcyc.size() >= 1) chk("simul_bubble", gcyc[1] - rcyc[0], 64'd1);
        chk("simul_done0", done_count0, 64'd1);
        chk("simul_done1", done_count1, 64'd1);

        // Fairness with both always valid.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push0(32'(i + 1), 32'd10, 32'(i + 1) * 32'd10);
            push1(32'(i + 2), 32'(100 + i), 32'(i + 2) * 32'(100 + i));
        end
        for (int i = 0; i < 6; i++) exp_grant.push_back(i % 2);
        wait_drain("fair_drain", 200);
        chk("fair_grants_left", exp_grant.size(), 64'd0);
        chk("fair_done0", done_count0, 64'd3);
        chk("fair_done1", done_count1, 64'd3);

        // Spurious multiplier response while idle.
        @(posedge clk); #1 spur = 1'b1;
        repeat (3) @(negedge clk);
        chk("spur_resp", {resp0_val, resp1_val, imul_resp_rdy}, 64'd0);
        @(posedge clk); #1 spur = 1'b0;
        chk("spur_done0", done_count0, 64'd3);

        // Backpressure on requester 1.
        do_reset();
        resp1_rdy = 1'b0;
        push1(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE); exp_grant.push_back(1);
        n = 0;
        do begin @(negedge clk); n++; end while (!resp1_val && n < 50);
        chk("bp_resp_seen", {63'd0, resp1_val}, 64'd1);
        push0(32'd1, 32'd1, 32'd1); exp_grant.push_back(0);
        repeat (10) begin
            @(negedge clk);
            chk("bp_val", {63'd0, resp1_val}, 64'd1);
            chk("bp_msg", resp1_msg, 64'hFFFF_FFFE);
            chk("bp_req0_rdy", {63'd0, req0_rdy}, 64'd0);
        end
        chk("bp_no_grant", gcyc.size(), 64'd1);
        @(posedge clk); #1 resp1_rdy = 1'b1;
        wait_drain("bp_drain", 100);
        chk("bp_done0", done_count0, 64'd1);
        chk("bp_done1", done_count1, 64'd1);

        // Requester drops val before the handshake: no effect.
        do_reset();
        agent_en = 1'b0; mstall = 1'b1;
        @(posedge clk); #1 req0_val = 1'b1; req0_msg = {32'd5, 32'd6};
        @(negedge clk);
        chk("drop_req_val", {63'd0, imul_req_val}, 64'd1);
        chk("drop_req_msg", imul_req_msg, {32'd5, 32'd6});
        chk("drop_rdy", {req0_rdy, req1_rdy}, 64'd0);
        @(posedge clk); #1 req0_val = 1'b0;
        @(negedge clk);
        chk("drop_gone", {63'd0, imul_req_val}, 64'd0);
        @(posedge clk); #1 mstall = 1'b0; agent_en = 1'b1;
        push0(32'd1, 32'd2, 32'd2); push1(32'd3, 32'd3, 32'd9);
        exp_grant.push_back(0); exp_grant.push_back(1);
        wait_drain("drop_drain", 100);
        chk("drop_done0", done_count0, 64'd1);

        // Reset while a transaction is outstanding.
        do_reset();
        push0(32'd9, 32'd9, 32'd81); exp_grant.push_back(0);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_busy && n < 20);
        chk("rb_busy", {63'd0, m_busy}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        src0.delete(); exp0.delete();
        @(negedge clk);
        chk("rb_resp0_val", {63'd0, resp0_val}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rb_done0", done_count0, 64'd0);
        chk("rb_done1", done_count1, 64'd0);
        repeat (6) @(negedge clk);
        push1(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE); exp_grant.push_back(1);
        wait_drain("rb_drain", 100);
        chk("rb_after_done1", done_count1, 64'd1);
        chk("rb_after_done0", done_count0, 64'd0);

        // Counter wrap from a forced preload.
        @(negedge clk);
        force dut.done_count0 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.done_count0;
        @(negedge clk);
        chk("wrap_preload", done_count0, 64'hFFFF_FFFF);
        push0(32'd6, 32'd7, 32'd42); exp_grant.push_back(0);
        wait_drain("wrap_drain", 100);
        chk("wrap_done0", done_count0, 64'd0);
        chk("wrap_done1", done_count1, 64'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
